// File: rtl/period_meter.sv
// period_meter: measures clk cycles between rising edges of event_in, valid/ready result with saturation and drop flag
module period_meter #(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     event_in,
    input  logic                     meas_ready,
    output logic                     meas_valid,
    output logic [COUNTER_WIDTH-1:0] meas_count,
    output logic                     meas_overflow,
    output logic                     dropped,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ARMED, MEASURING} state_t;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    state_t                   state, state_nxt;
    logic [COUNTER_WIDTH-1:0] count, count_nxt;
    logic                     ovf_run, ovf_nxt;
    logic                     event_d;
    logic                     edge_det;
    logic                     load;
    assign edge_det = event_in & ~event_d;
    assign busy     = state != IDLE;
    // next state, period counter and result strobe; a low enable wins over a coincident edge
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = ovf_run;
        load      = 1'b0;
        if (state == IDLE) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            state_nxt = enable ? ARMED : IDLE;
        end else if (!enable) begin
            state_nxt = IDLE;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (state == ARMED) begin
            state_nxt = edge_det ? MEASURING : ARMED;
            count_nxt = edge_det ? CNT_ONE : count;
        end else if (edge_det) begin
            load      = 1'b1;
            count_nxt = CNT_ONE;
            ovf_nxt   = 1'b0;
        end else begin
            count_nxt = (count == CNT_MAX) ? count : count + CNT_ONE;
            ovf_nxt   = ovf_run | (count == CNT_MAX);
        end
    end
    // state, counter and edge-detect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            ovf_run <= 1'b0;
            event_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            ovf_run <= ovf_nxt;
            event_d <= event_in;
        end
    end
    // result holding register with handshake and sticky drop on unaccepted overwrite
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_valid    <= 1'b0;
            meas_count    <= '0;
            meas_overflow <= 1'b0;
            dropped       <= 1'b0;
        end else if (load) begin
            meas_valid    <= 1'b1;
            meas_count    <= count;
            meas_overflow <= ovf_run;
            dropped       <= dropped | (meas_valid & ~meas_ready);
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter measurement, saturation, drop, enable and reset behaviour
module tb_period_meter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       event_in = 1'b0;
    logic       meas_ready = 1'b1;
    logic       meas_valid;
    logic [7:0] meas_count;
    logic       meas_overflow;
    logic       dropped;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    period_meter #(.COUNTER_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .event_in(event_in),
        .meas_ready(meas_ready), .meas_valid(meas_valid), .meas_count(meas_count),
        .meas_overflow(meas_overflow), .dropped(dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        event_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic edge1();
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        event_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_result(input string tag, input int cnt, input logic ovf);
        check({tag, "_valid"}, 32'(meas_valid), 32'd1);
        check({tag, "_count"}, 32'(meas_count), 32'(cnt));
        check({tag, "_ovf"}, 32'(meas_overflow), 32'(ovf));
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_count", 32'(meas_count), 32'd0);
        check("rst_ovf", 32'(meas_overflow), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        do_reset();

        // basic periods 7 and 12
        enable = 1'b1;
        meas_ready = 1'b1;
        tick();
        check("armed_busy", 32'(busy), 32'd1);
        edge1();
        check("arm_no_result", 32'(meas_valid), 32'd0);
        idle_cycles(6);
        edge1();
        check_result("p7", 7, 1'b0);
        check("p7_dropped", 32'(dropped), 32'd0);
        idle_cycles(1);
        check("p7_consumed", 32'(meas_valid), 32'd0);
        check("p7_kept", 32'(meas_count), 32'd7);
        idle_cycles(10);
        edge1();
        check_result("p12", 12, 1'b0);

        // saturation boundary 255 then 300
        idle_cycles(254);
        edge1();
        check_result("p255", 255, 1'b0);
        idle_cycles(299);
        edge1();
        check_result("p300", 255, 1'b1);

        // backpressure and drop
        do_reset();
        enable = 1'b1;
        meas_ready = 1'b0;
        tick();
        edge1();
        idle_cycles(4);
        edge1();
        check_result("bp5", 5, 1'b0);
        check("bp5_dropped", 32'(dropped), 32'd0);
        idle_cycles(3);
        check("bp5_hold_valid", 32'(meas_valid), 32'd1);
        check("bp5_hold_count", 32'(meas_count), 32'd5);
        idle_cycles(3);
        edge1();
        check_result("bp7", 7, 1'b0);
        check("bp7_dropped", 32'(dropped), 32'd1);
        meas_ready = 1'b1;
        tick();
        check("bp_accept", 32'(meas_valid), 32'd0);
        check("bp_drop_sticky", 32'(dropped), 32'd1);

        // enable drop discards partial period
        do_reset();
        check("rst_clears_drop", 32'(dropped), 32'd0);
        enable = 1'b1;
        tick();
        edge1();
        idle_cycles(9);
        edge1();
        check_result("en10", 10, 1'b0);
        idle_cycles(4);
        enable = 1'b0;
        tick();
        check("en_idle_busy", 32'(busy), 32'd0);
        idle_cycles(2);
        enable = 1'b1;
        tick();
        check("en_rearm_busy", 32'(busy), 32'd1);
        idle_cycles(5);
        edge1();
        check("en_arm_only", 32'(meas_valid), 32'd0);
        idle_cycles(3);
        edge1();
        check_result("en4", 4, 1'b0);

        // asynchronous reset with pending result
        meas_ready = 1'b0;
        idle_cycles(2);
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(meas_valid), 32'd0);
        check("ar_count", 32'(meas_count), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        meas_ready = 1'b1;
        tick();
        edge1();
        check("ar_arm_only", 32'(meas_valid), 32'd0);
        idle_cycles(5);
        edge1();
        check_result("ar6", 6, 1'b0);

        // long high level counts once, then period-2 toggling
        do_reset();
        enable = 1'b1;
        tick();
        event_in = 1'b1;
        repeat (50) tick();
        check("hi_no_result", 32'(meas_valid), 32'd0);
        idle_cycles(10);
        edge1();
        check_result("hi60", 60, 1'b0);
        idle_cycles(1);
        edge1();
        check_result("t2a", 2, 1'b0);
        idle_cycles(1);
        edge1();
        check_result("t2b", 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
